// File: rtl/any1_pkg.sv
// any1_pkg: shared types and constants for the any1 front end.
// Defines the decoded-instruction record (sDecode) passed from the decoder to
// rename/issue, and the default sizing of the decode queue.
package any1_pkg;

  // Default decode-queue sizing.
  localparam int DQ_DEPTH = 8;
  localparam int DQ_AFULL = 6;

  typedef struct packed {
    logic [63:0] val;
  } sImm;

  typedef struct packed {
    logic [31:0] ip;      // instruction pointer
    logic [7:0]  opcode;
    logic [5:0]  Ra;
    logic [5:0]  Rb;
    logic [5:0]  Rt;
    sImm         imm;
    logic [3:0]  Stream;  // hardware thread / stream id
    logic [4:0]  rid;     // reorder id hint
    logic        ui;      // unimplemented instruction
    logic        nop;
  } sDecode;

endpackage

// File: rtl/any1_decode_queue.sv
// any1_decode_queue: in-order FIFO decoupling the decoder from rename/issue.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   flush_i                discard every held record (push/pop that cycle ignored)
//   dec_v_i, dec_i         record presented by the decoder
//   dec_rdy_o              queue can accept a record (not full)
//   deq_v_o, deq_o         oldest held record, valid when not empty
//   deq_rdy_i              consumer takes deq_o this cycle
//   count_o                occupancy
//   afull_o, empty_o       occupancy >= AFULL, occupancy == 0
// Every output is driven from registered state only.
module any1_decode_queue
  import any1_pkg::*;
#(
  parameter int DEPTH = DQ_DEPTH,
  parameter int AFULL = DQ_AFULL
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     dec_v_i,
  input  sDecode                   dec_i,
  output logic                     dec_rdy_o,
  output logic                     deq_v_o,
  output sDecode                   deq_o,
  input  logic                     deq_rdy_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     afull_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL);

  sDecode          mem [DEPTH];
  logic [AW-1:0]   rp;
  logic [AW-1:0]   wp;
  logic [CW-1:0]   cnt;
  logic            push;
  logic            pop;

  assign dec_rdy_o = (cnt != FULL_CNT);
  assign deq_v_o   = (cnt != '0);
  assign empty_o   = (cnt == '0);
  assign afull_o   = (cnt >= AFULL_CNT);
  assign count_o   = cnt;
  assign deq_o     = mem[rp];

  // A full queue refuses a push even if a pop happens in the same cycle, so
  // dec_rdy_o never depends on deq_rdy_i.
  assign push = dec_v_i && dec_rdy_o && !flush_i;
  assign pop  = deq_v_o && deq_rdy_i && !flush_i;

  // Control state: pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else if (flush_i) begin
      rp  <= '0;
      wp  <= '0;
      cnt <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Record storage; contents are never cleared, pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (push) mem[wp] <= dec_i;
  end

endmodule

// File: doc/any1_decode_queue.md
# any1_decode_queue

Decoupling FIFO between the combinational decoder and the rename/issue stage. It captures each decoded record (`sDecode`) the cycle it is presented, holds up to DEPTH records in program order, and presents the oldest one to the downstream consumer with a valid/ready handshake. It provides back-pressure and an almost-full hint to fetch/align, and it discards all held records on a pipeline flush (branch mispredict, exception).

## Interface
- `DEPTH`, 8: number of entries; power of two, ≥ 2.
- `AFULL`, DEPTH-2: occupancy at or above which `afull_o` asserts; must satisfy 1 ≤ AFULL ≤ DEPTH.

- `rst_ni` input 1: asynchronous reset, active-low.
- `clk_i` input 1: single clock; all state updates on its rising edge.
- `flush_i` input 1: discard all entries this cycle.
- `dec_v_i` input 1: a decode record is presented on `dec_i`.
- `dec_i` input `sDecode`: record from the decoder.
- `dec_rdy_o` output 1: the queue can accept a record this cycle.
- `deq_v_o` output 1: `deq_o` holds a valid record.
- `deq_o` output `sDecode`: oldest held record.
- `deq_rdy_i` input 1: the consumer takes `deq_o` this cycle.
- `count_o` output $clog2(DEPTH)+1: current occupancy.
- `afull_o` output 1: `count_o >= AFULL`.
- `empty_o` output 1: `count_o == 0`.

## Operation
- Storage is a DEPTH-entry array of `sDecode` with read pointer `rp`, write pointer `wp` (each $clog2(DEPTH) bits, natural wrap), and `cnt` ($clog2(DEPTH)+1 bits).
- Push condition: `dec_v_i && dec_rdy_o && !flush_i`. The record is written to `mem[wp]` and `wp` increments.
- Pop condition: `deq_v_o && deq_rdy_i && !flush_i`. `rp` increments.
- `cnt` update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both or neither occur.
- Flush: `rp`, `wp` and `cnt` all go to 0. A push or pop presented in the same cycle is ignored. Array contents are not cleared.
- Status outputs:
  - `dec_rdy_o = (cnt != DEPTH)`. A push is refused when full even if a pop occurs that cycle; there is no full-queue pass-through.
  - `deq_v_o = (cnt != 0)`.
  - `deq_o = mem[rp]`.
- Records are stored and returned unmodified. The queue does not filter NOPs or `ui` records and does not inspect `rid`/`Stream`. Ordering is strict FIFO.
- Push while `dec_rdy_o` = 0: the record is not stored, and the decoder/aligner must hold it. This is not an error.
- Pop while `deq_v_o` = 0: no effect.

## Timing
- Reset (asynchronous assert, synchronous release via the clock edge):
  - `rp = wp = cnt = 0`.
  - `dec_rdy_o` = 1, `deq_v_o` = 0, `empty_o` = 1, `afull_o` = 0, `count_o` = 0.
  - `deq_o` is don't-care.
- Reset asserted mid-operation drops all entries immediately; there is no completion of in-flight handshakes.
- Latency: a record pushed into an empty queue at edge N is valid on `deq_o` after edge N. There is 1 cycle of latency and no same-cycle bypass.
- All status outputs are functions of registered state only, with no combinational path from any input. `deq_o` depends only on registered `rp` and the array.
- Full with simultaneous pop: the pop occurs, `cnt` becomes DEPTH−1, and `dec_rdy_o` returns to 1 the next cycle.
- Empty with simultaneous push: the push occurs, and the pop is ignored because `deq_v_o` = 0.
- Pointer wrap: after DEPTH pushes, `wp` returns to 0. `cnt` distinguishes full from empty when `rp == wp`.

## Structure
- `sDecode` comes from `any1_pkg`; no new types are needed.
- Add to `any1_pkg`:
  - `DQ_DEPTH` default constant (8).
  - `DQ_AFULL` default constant (6).
- Storage is a plain register array inferred inside the module; one flat module, no sub-module.
- A future multi-issue variant would factor a generic `any1_fifo` sub-module. It is not built now.

## Test plan
- Reset/idle: assert `rst_ni`=0 mid-run with 5 entries held → outputs immediately show `count_o`=0, `empty_o`=1, `dec_rdy_o`=1, `deq_v_o`=0.
- Fill and drain, DEPTH=8:
  - Push 8 records with `ip` = 0x100, 0x108, …, 0x138, `deq_rdy_i`=0 → `dec_rdy_o`=0 after the 8th edge, `afull_o`=1 from `count_o`=6.
  - Then hold `deq_rdy_i`=1 → `deq_o.ip` emerges 0x100…0x138 in order and `empty_o`=1 after 8 edges.
- Simultaneous push/pop at `count_o`=3 for 20 cycles → `count_o` stays 3, output order matches input order, and pointers wrap twice without a glitch.
- Full plus pop plus push attempt: at `count_o`=8, `dec_v_i`=1 and `deq_rdy_i`=1 → only the pop happens, `count_o`=7, and the presented record is not stored.
- Flush: at `count_o`=5, `flush_i`=1 with `dec_v_i`=1 and `deq_rdy_i`=1 → next cycle `count_o`=0, `deq_v_o`=0; a subsequent push of `ip`=0x200 appears on `deq_o` one cycle later.
- Latency: push one record into an empty queue → `deq_v_o`=1 exactly one edge later and `deq_o` equals the pushed record bit-for-bit, including `imm.val`, `Rt` and `Stream`.
